// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/ack port plus the decoded-op
// handshake toward the executing stage. master = fetch unit, slave = its environment.
interface instr_fetch_if #(
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;
    logic          op_valid;
    logic [15:0]   op_code;
    logic [AW-1:0] pc_out;
    logic          op_ready;
    logic          br;
    logic [AW-1:0] br_target;

    modport master (
        output imem_req, imem_addr, op_valid, op_code, pc_out,
        input  imem_ack, imem_rdata, op_ready, br, br_target
    );

    modport slave (
        input  imem_req, imem_addr, op_valid, op_code, pc_out,
        output imem_ack, imem_rdata, op_ready, br, br_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction prefetcher: sequential fetch into a small {word, address} FIFO,
// flushed and redirected by a taken branch.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | one dead cycle after reset before the first request
// S_REQ   | request fetch_pc from memory, held until ack or branch
// S_HOLD  | FIFO full, no request until the executing stage pops
// S_FLUSH | one request-free cycle after a branch redirect
module instr_fetch #(
    parameter int AW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FLUSH} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d, count_after;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [15:0]   word_q [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];
    logic          push, pop, op_valid;

    assign op_valid = (count_q != '0);

    always_comb begin
        push        = (state_q == S_REQ) && bus.imem_ack && !bus.br;
        pop         = op_valid && bus.op_ready && !bus.br;
        count_after = count_q + CW'(push) - CW'(pop);
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        // A taken branch wins over any same-cycle push/pop; the acked word is dropped.
        if (bus.br) begin
            state_d    = S_FLUSH;
            fetch_pc_d = bus.br_target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            count_d = count_after;
            if (push) begin
                fetch_pc_d = fetch_pc_q + AW'(1);
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case (state_q)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   state_d = (push && count_after == CW'(DEPTH)) ? S_HOLD : S_REQ;
                S_HOLD:  state_d = (count_after < CW'(DEPTH)) ? S_REQ : S_HOLD;
                S_FLUSH: state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= bus.imem_rdata;
            addr_q[wr_ptr_q] <= fetch_pc_q;
        end
    end

    assign bus.imem_req  = (state_q == S_REQ);
    assign bus.imem_addr = fetch_pc_q;
    assign bus.op_valid  = op_valid;
    assign bus.op_code   = op_valid ? word_q[rd_ptr_q] : '0;
    assign bus.pc_out    = op_valid ? addr_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model checked every cycle, with
// directed branch/full/wrap/reset scenarios followed by randomized traffic.
module tb_instr_fetch;
    localparam int AW    = 8;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ack, ready, br, dmode;
    logic [7:0]  tgt;
    logic [15:0] rnd_data;
    int          checks   = 0;
    int          failures = 0;

    instr_fetch_if #(.AW(AW)) bus ();

    instr_fetch #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_ack   = ack;
    assign bus.op_ready   = ready;
    assign bus.br         = br;
    assign bus.br_target  = tgt;
    assign bus.imem_rdata = dmode ? (16'hA000 | {8'h00, bus.imem_addr}) : rnd_data;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of {word, addr}, fetch pointer, and count of
    // request-free cycles still owed (one after reset, one after each branch).
    logic [23:0] m_q[$];
    logic [7:0]  m_pc;
    int          m_gap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc  = 8'h00;
            m_gap = 1;
        end else begin
            bit m_req;
            m_req = (m_gap == 0) && (m_q.size() < DEPTH);
            if (br) begin
                m_q.delete();
                m_pc  = tgt;
                m_gap = 1;
            end else begin
                if (m_q.size() > 0 && ready) void'(m_q.pop_front());
                if (m_req && ack) begin
                    m_q.push_back({bus.imem_rdata, m_pc});
                    m_pc = m_pc + 8'h01;
                end
                if (m_gap > 0) m_gap--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit          exp_req;
            logic [23:0] head;
            exp_req = (m_gap == 0) && (m_q.size() < DEPTH);
            chk("m_imem_req", 32'(bus.imem_req), 32'(exp_req));
            if (exp_req) chk("m_imem_addr", 32'(bus.imem_addr), 32'(m_pc));
            chk("m_op_valid", 32'(bus.op_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                head = m_q[0];
                chk("m_op_code", 32'(bus.op_code), 32'(head[23:8]));
                chk("m_pc_out", 32'(bus.pc_out), 32'(head[7:0]));
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ack = 1'b0; ready = 1'b0; br = 1'b0; tgt = 8'h00;
        dmode = 1'b1; rnd_data = 16'h0000;
        repeat (3) tick;
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_addr", 32'(bus.imem_addr), 0);
        chk("rst_valid", 32'(bus.op_valid), 0);
        chk("rst_code", 32'(bus.op_code), 0);
        chk("rst_pc", 32'(bus.pc_out), 0);

        // streaming from reset release
        rst_n = 1'b1; ack = 1'b1; ready = 1'b1;
        tick;
        chk("first_req", 32'(bus.imem_req), 1);
        chk("first_addr", 32'(bus.imem_addr), 0);
        tick;
        chk("lat_valid", 32'(bus.op_valid), 1);
        chk("lat_pc", 32'(bus.pc_out), 0);
        chk("lat_code", 32'(bus.op_code), 32'hA000);
        chk("lat_addr", 32'(bus.imem_addr), 1);
        tick;
        chk("stream_pc", 32'(bus.pc_out), 1);
        chk("stream_code", 32'(bus.op_code), 32'hA001);
        repeat (4) tick;

        // fill with pc 5,6 then branch to 0x40 while full
        br = 1'b1; tgt = 8'h05; ready = 1'b0;
        tick; br = 1'b0;
        chk("flush_req", 32'(bus.imem_req), 0);
        chk("flush_valid", 32'(bus.op_valid), 0);
        tick;
        chk("redir_addr5", 32'(bus.imem_addr), 32'h05);
        tick; tick;
        chk("full_req", 32'(bus.imem_req), 0);
        chk("full_pc", 32'(bus.pc_out), 32'h05);
        br = 1'b1; tgt = 8'h40;
        tick; br = 1'b0;
        chk("brfull_valid", 32'(bus.op_valid), 0);
        chk("brfull_req", 32'(bus.imem_req), 0);
        tick;
        chk("br40_req", 32'(bus.imem_req), 1);
        chk("br40_addr", 32'(bus.imem_addr), 32'h40);

        // stalled consumer: exactly DEPTH pushes, then one request per pop
        tick; tick;
        chk("hold_req", 32'(bus.imem_req), 0);
        tick;
        chk("hold_req2", 32'(bus.imem_req), 0);
        ready = 1'b1;
        tick; ready = 1'b0;
        chk("room_req", 32'(bus.imem_req), 1);
        chk("room_addr", 32'(bus.imem_addr), 32'h42);
        chk("room_pc", 32'(bus.pc_out), 32'h41);
        tick;
        chk("rehold_req", 32'(bus.imem_req), 0);
        tick;
        chk("rehold_req2", 32'(bus.imem_req), 0);

        // branch coincident with ack of 0x12 discards that word
        ready = 1'b1; ack = 1'b0; br = 1'b1; tgt = 8'h12;
        tick; br = 1'b0;
        tick;
        chk("pre12_addr", 32'(bus.imem_addr), 32'h12);
        ack = 1'b1; br = 1'b1; tgt = 8'h30;
        tick; br = 1'b0;
        chk("drop_valid", 32'(bus.op_valid), 0);
        tick;
        chk("drop_valid2", 32'(bus.op_valid), 0);
        chk("drop_next_addr", 32'(bus.imem_addr), 32'h30);
        tick;
        chk("drop_pc", 32'(bus.pc_out), 32'h30);
        chk("drop_code", 32'(bus.op_code), 32'hA030);

        // branch again during flush extends it and takes the newer target
        br = 1'b1; tgt = 8'h50;
        tick; tgt = 8'h60;
        tick; br = 1'b0;
        chk("reflush_req", 32'(bus.imem_req), 0);
        tick;
        chk("reflush_addr", 32'(bus.imem_addr), 32'h60);

        // address wrap at 0xFF
        br = 1'b1; tgt = 8'hFF;
        tick; br = 1'b0;
        tick;
        chk("wrap_addr_ff", 32'(bus.imem_addr), 32'hFF);
        tick;
        chk("wrap_addr_00", 32'(bus.imem_addr), 32'h00);
        chk("wrap_pc_ff", 32'(bus.pc_out), 32'hFF);
        chk("wrap_code_ff", 32'(bus.op_code), 32'hA0FF);
        tick;
        chk("wrap_pc_00", 32'(bus.pc_out), 32'h00);
        chk("wrap_code_00", 32'(bus.op_code), 32'hA000);

        // asynchronous reset mid-request with one entry held
        chk("prerst_req", 32'(bus.imem_req), 1);
        chk("prerst_valid", 32'(bus.op_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", 32'(bus.imem_req), 0);
        chk("async_valid", 32'(bus.op_valid), 0);
        chk("async_addr", 32'(bus.imem_addr), 0);
        tick; rst_n = 1'b1;
        tick;
        chk("restart_req", 32'(bus.imem_req), 1);
        chk("restart_addr", 32'(bus.imem_addr), 0);

        // randomized traffic, checked by the model only
        dmode = 1'b0;
        repeat (3000) begin
            ack      = ($urandom_range(0, 9) < 6);
            ready    = ($urandom_range(0, 9) < 7);
            br       = ($urandom_range(0, 19) == 0);
            tgt      = 8'($urandom);
            rnd_data = 16'($urandom);
            tick;
        end
        br = 1'b0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
